// File: rtl/mod_alu_arb.sv
// Two-requester round-robin front end for one shared signed-digit ALU.
// It keeps a single operation in flight, bounds each run with a timeout and holds the result until the consumer takes it.
package mod_alu_arb_pkg;
    typedef logic [1:0] sd2_t;
endpackage

module mod_alu_arb
    import mod_alu_arb_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned TIMEOUT = 4 * N + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  sd2_t [N-1:0]     req0_m,
    input  sd2_t [N-1:0]     req0_x,
    input  sd2_t [N-1:0]     req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  sd2_t [N-1:0]     req1_m,
    input  sd2_t [N-1:0]     req1_x,
    input  sd2_t [N-1:0]     req1_y,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output sd2_t [N-1:0]     resp_z,
    output logic             resp_err,
    output logic             alu_rst,
    output logic             alu_mode,
    output sd2_t [N-1:0]     alu_m,
    output sd2_t [N-1:0]     alu_x,
    output sd2_t [N-1:0]     alu_y,
    input  sd2_t [N-1:0]     alu_z,
    input  logic             alu_done
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t         state;
    logic           last_grant;
    logic           grant_c;
    logic [CW-1:0]  cnt;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        grant_c    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant;
        end else begin
            grant_c = req1_valid;
        end
        if (state == IDLE) begin
            req0_ready = req0_valid && !grant_c;
            req1_ready = req1_valid && grant_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_z     <= '0;
            resp_err   <= 1'b0;
            alu_rst    <= 1'b1;
            alu_mode   <= 1'b0;
            alu_m      <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        resp_id    <= grant_c;
                        last_grant <= grant_c;
                        alu_mode   <= grant_c ? req1_mode : req0_mode;
                        alu_m      <= grant_c ? req1_m : req0_m;
                        alu_x      <= grant_c ? req1_x : req0_x;
                        alu_y      <= grant_c ? req1_y : req0_y;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    cnt     <= '0;
                    alu_rst <= 1'b0;
                    state   <= RUN;
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    // A done pulse on the last allowed cycle still counts as success.
                    if (alu_done) begin
                        resp_z     <= alu_z;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        alu_rst    <= 1'b1;
                        state      <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        resp_z     <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        alu_rst    <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_alu_arb.sv
// Self-checking bench for mod_alu_arb: the bench plays the ALU and keeps a scoreboard of expected responses.
module tb_mod_alu_arb;
    import mod_alu_arb_pkg::*;

    localparam int unsigned N       = 8;
    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned DW      = 2 * N;
    localparam int unsigned NO_DONE = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_mode;
    logic         req1_valid, req1_ready, req1_mode;
    sd2_t [N-1:0] req0_m, req0_x, req0_y, req1_m, req1_x, req1_y;
    logic         resp_valid, resp_ready, resp_id, resp_err;
    sd2_t [N-1:0] resp_z;
    logic         alu_rst, alu_mode, alu_done;
    sd2_t [N-1:0] alu_m, alu_x, alu_y, alu_z;

    mod_alu_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_m(req0_m), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_m(req1_m), .req1_x(req1_x), .req1_y(req1_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_z(resp_z), .resp_err(resp_err),
        .alu_rst(alu_rst), .alu_mode(alu_mode), .alu_m(alu_m), .alu_x(alu_x),
        .alu_y(alu_y), .alu_z(alu_z), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v0;
        logic          v1;
        int unsigned   dd;
        logic [DW-1:0] z;
        int unsigned   rdl;
        logic          exp_id;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] z;
        logic          err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req0_mode = 1'($urandom);
        req1_mode = 1'($urandom);
        req0_m = DW'($urandom); req0_x = DW'($urandom); req0_y = DW'($urandom);
        req1_m = DW'($urandom); req1_x = DW'($urandom); req1_y = DW'($urandom);
    endtask

    task automatic chk_ops(input string ph, input logic md, input logic [DW-1:0] m,
                           input logic [DW-1:0] x, input logic [DW-1:0] y);
        chk({ph, "_alu_mode"}, 32'(alu_mode), 32'(md));
        chk({ph, "_alu_m"}, 32'(alu_m), 32'(m));
        chk({ph, "_alu_x"}, 32'(alu_x), 32'(x));
        chk({ph, "_alu_y"}, 32'(alu_y), 32'(y));
    endtask

    // One full operation: accept, LOAD, RUN until done/timeout, RESP with optional backpressure.
    task automatic do_op(input vec_t v);
        logic          em;
        logic [DW-1:0] m, x, y;
        exp_t          e;
        req0_valid = v.v0;
        req1_valid = v.v1;
        resp_ready = 1'b0;
        scramble();
        #1;
        chk("accept_req0_ready", 32'(req0_ready), 32'(v.exp_id == 1'b0));
        chk("accept_req1_ready", 32'(req1_ready), 32'(v.exp_id == 1'b1));
        em = v.exp_id ? req1_mode : req0_mode;
        m  = v.exp_id ? DW'(req1_m) : DW'(req0_m);
        x  = v.exp_id ? DW'(req1_x) : DW'(req0_x);
        y  = v.exp_id ? DW'(req1_y) : DW'(req0_y);
        sb.push_back('{v.exp_id, v.exp_err ? '0 : v.z, v.exp_err});
        step();
        scramble();
        chk("load_alu_rst", 32'(alu_rst), 32'd1);
        chk("load_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk_ops("load", em, m, x, y);
        step();
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            chk("run_alu_rst", 32'(alu_rst), 32'd0);
            chk("run_resp_valid", 32'(resp_valid), 32'd0);
            chk("run_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk_ops("run", em, m, x, y);
            if (k == int'(v.dd)) begin
                alu_done = 1'b1;
                alu_z    = v.z;
                step();
                alu_done = 1'b0;
                alu_z    = DW'($urandom);
                break;
            end
            step();
        end
        e = sb.pop_front();
        for (int c = 0; c <= int'(v.rdl); c++) begin
            if (c == int'(v.rdl)) resp_ready = 1'b1;
            #1;
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_z", 32'(resp_z), 32'(e.z));
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp_alu_rst", 32'(alu_rst), 32'd1);
            chk("resp_ready_blocked", 32'({req0_ready, req1_ready}), 32'd0);
            chk_ops("resp", em, m, x, y);
            step();
        end
        resp_ready = 1'b0;
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_alu_rst", 32'(alu_rst), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        alu_done = 1'b0; alu_z = '0;
        scramble();
        vecs[0] = '{1'b1, 1'b0, 8,           16'hA5C3, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 3,           16'h1234, 0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 0,           16'h5A5A, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 12,          16'hFFFF, 1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 5,           16'h0F0F, 0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, NO_DONE,     16'hBEEF, 5, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, TIMEOUT - 1, 16'hC001, 0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 0,           16'h8421, 2, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 20,          16'h7E81, 0, 1'b1, 1'b0};
        step();
        step();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_z", 32'(resp_z), 32'd0);
        chk("rst_alu_rst", 32'(alu_rst), 32'd1);
        chk_ops("rst", 1'b0, '0, '0, '0);
        rst = 1'b0;
        step();
        chk("idle_no_req_ready", 32'({req0_ready, req1_ready}), 32'd0);

        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // alu_done while idle must not produce a response.
        req0_valid = 1'b0; req1_valid = 1'b0;
        alu_done = 1'b1; alu_z = DW'(16'h3C3C);
        step();
        alu_done = 1'b0;
        chk("stray_done_resp_valid", 32'(resp_valid), 32'd0);
        chk("stray_done_alu_rst", 32'(alu_rst), 32'd1);
        step();
        chk("stray_done_resp_valid2", 32'(resp_valid), 32'd0);

        // Reset in RUN aborts: operation granted to req0, then reset restores last_grant.
        req0_valid = 1'b1;
        scramble();
        #1;
        chk("abort_accept_ready0", 32'(req0_ready), 32'd1);
        sb.push_back('{1'b0, '0, 1'b0});
        step();
        req0_valid = 1'b0;
        step();
        step();
        chk("abort_in_run", 32'(alu_rst), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_alu_rst", 32'(alu_rst), 32'd1);
        chk("abort_resp_z", 32'(resp_z), 32'd0);
        chk_ops("abort", 1'b0, '0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        do_op('{1'b1, 1'b1, 4, 16'h2468, 0, 1'b0, 1'b0});
        do_op('{1'b0, 1'b1, 6, 16'h1357, 0, 1'b1, 1'b0});
        do_op('{1'b1, 1'b1, 2, 16'h9ABC, 0, 1'b0, 1'b0});

        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
